encoder: RTL and testbench

- Serial optical-link transmitter for the LightIO path.
- Latches a parallel frame on `start` and drives it onto a single LED line using Manchester coding, framed by a sync symbol and a stop symbol.
- Raises `irq` when the frame has been fully emitted and holds it until the host acknowledges.
- Sits between the host/register interface and the LED driver pin.

---
 rtl/encoder.sv | 164 ++++++++++++++++
 tb/tb_encoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/encoder.sv
// Manchester optical-link transmitter: sync symbol, FRAME_SIZE data symbols MSB first, stop symbol, then irq.
// Latency: led changes on the accepting edge; irq rises (FRAME_SIZE+2)*2*HALF_PERIOD cycles later.
// Backpressure: none; start is a level request, ignored mid-frame, and irq holds until start drops.
module encoder #(
  parameter int FRAME_SIZE  = 16,
  parameter int HALF_PERIOD = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [FRAME_SIZE-1:0] data,
  input  logic                  start,
  output logic                  led,
  output logic                  irq
);

  localparam int TC_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int BC_W = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(HALF_PERIOD - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(FRAME_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [TC_W-1:0]         tcnt_q, tcnt_d;   // cycle within a half-symbol
  logic                    phase_q, phase_d; // 0 = first half, 1 = second half
  logic [BC_W-1:0]         bcnt_q, bcnt_d;   // data symbol index
  logic [FRAME_SIZE-1:0]   shreg_q, shreg_d; // latched frame, MSB is the current bit
  logic                    led_q, led_d;
  logic                    irq_q, irq_d;

  logic                    half_end;
  logic [FRAME_SIZE-1:0]   shreg_next;

  assign half_end   = (tcnt_q == TC_LAST);
  assign shreg_next = shreg_q << 1;

  // Next-state logic: sequences the symbols and computes the registered led/irq values
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    phase_d = phase_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    led_d   = led_q;
    irq_d   = irq_q;

    case (state_q)
      S_IDLE: begin
        led_d   = 1'b0;
        irq_d   = 1'b0;
        tcnt_d  = '0;
        phase_d = 1'b0;
        bcnt_d  = '0;
        if (start) begin
          shreg_d = data;
          led_d   = 1'b1;
          state_d = S_SYNC;
        end
      end

      S_SYNC: begin
        if (half_end) begin
          tcnt_d = '0;
          if (phase_q) begin
            // Sync done: present the first half of the MSB symbol
            phase_d = 1'b0;
            state_d = S_DATA;
            led_d   = shreg_q[FRAME_SIZE-1];
          end else begin
            phase_d = 1'b1;
          end
        end else begin
          tcnt_d = tcnt_q + TC_W'(1);
        end
      end

      S_DATA: begin
        if (half_end) begin
          tcnt_d = '0;
          if (!phase_q) begin
            // Mid-symbol transition: second half is the complement
            phase_d = 1'b1;
            led_d   = ~shreg_q[FRAME_SIZE-1];
          end else begin
            phase_d = 1'b0;
            if (bcnt_q == BC_LAST) begin
              bcnt_d  = '0;
              state_d = S_STOP;
              led_d   = 1'b0;
            end else begin
              bcnt_d  = bcnt_q + BC_W'(1);
              shreg_d = shreg_next;
              led_d   = shreg_next[FRAME_SIZE-1];
            end
          end
        end else begin
          tcnt_d = tcnt_q + TC_W'(1);
        end
      end

      S_STOP: begin
        led_d = 1'b0;
        if (half_end) begin
          tcnt_d = '0;
          if (phase_q) begin
            phase_d = 1'b0;
            state_d = S_DONE;
            irq_d   = 1'b1;
          end else begin
            phase_d = 1'b1;
          end
        end else begin
          tcnt_d = tcnt_q + TC_W'(1);
        end
      end

      S_DONE: begin
        led_d = 1'b0;
        // start low acknowledges the interrupt
        if (!start) begin
          irq_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        led_d   = 1'b0;
        irq_d   = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset; reset aborts any frame in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      tcnt_q  <= '0;
      phase_q <= 1'b0;
      bcnt_q  <= '0;
      shreg_q <= '0;
      led_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      phase_q <= phase_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      led_q   <= led_d;
      irq_q   <= irq_d;
    end
  end

  assign led = led_q;
  assign irq = irq_q;

endmodule

// File: tb/tb_encoder.sv
module tb_encoder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] data  = 16'h0000;
  logic        start = 1'b0;
  logic        led;
  logic        irq;

  integer errors = 0;
  integer checks = 0;
  logic [71:0] led_hist;

  encoder #(.FRAME_SIZE(16), .HALF_PERIOD(2)) dut (
    .clock(clock),
    .reset(reset),
    .data (data),
    .start(start),
    .led  (led),
    .irq  (irq)
  );

  always #5 clock = ~clock;

  // Expected led level in cycle k after the accepting edge E0 (defaults: 4-cycle symbols)
  function automatic logic exp_led(input int k, input logic [15:0] f);
    int  bi;
    logic b;
    if (k < 4) return 1'b1;
    if (k >= 68) return 1'b0;
    bi = 15 - (k - 4) / 4;
    b  = f[bi];
    if (((k - 4) % 4) < 2) return b;
    return ~b;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present a frame and let the accepting edge E0 pass; returns #1 after E0
  task automatic start_frame(input logic [15:0] d);
    data  = d;
    start = 1'b1;
    step();
  endtask

  // Walk cycles E0..E0+71 checking led/irq, then check irq at E0+72
  task automatic check_frame(input logic [15:0] f, input string name,
                             input bit chg_data, input bit drop_start);
    logic e;
    for (int k = 0; k < 72; k++) begin
      e = exp_led(k, f);
      led_hist[k] = led;
      checks++;
      if (led !== e) begin
        errors++;
        $display("FAIL %s led k=%0d got=%b expected=%b", name, k, led, e);
      end
      checks++;
      if (irq !== 1'b0) begin
        errors++;
        $display("FAIL %s early_irq k=%0d got=%b expected=0", name, k, irq);
      end
      if (chg_data && k == 1) data = 16'h0000;
      if (drop_start && k == 10) start = 1'b0;
      step();
    end
    checks++;
    if (irq !== 1'b1 || led !== 1'b0) begin
      errors++;
      $display("FAIL %s irq_at_72 got irq=%b led=%b expected irq=1 led=0", name, irq, led);
    end
  endtask

  task automatic ack(input string name);
    start = 1'b0;
    step();
    checks++;
    if (irq !== 1'b0 || led !== 1'b0) begin
      errors++;
      $display("FAIL %s ack got irq=%b led=%b expected irq=0 led=0", name, irq, led);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (led !== 1'b0 || irq !== 1'b0) begin
        errors++;
        $display("FAIL reset cyc=%0d got led=%b irq=%b expected 0 0", i, led, irq);
      end
    end
    reset = 1'b0;
    step();
    checks++;
    if (led !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got led=%b irq=%b expected 0 0", led, irq);
    end
  endtask

  task automatic test_frame_hold();
    start_frame(16'b0100_1111_1011_0110);
    check_frame(16'h4FB6, "frame", 1'b0, 1'b0);
    // Sync (4 ones), bit15=0 -> 0011, bit14=1 -> 1100; index 0 is LSB
    checks++;
    if (led_hist[11:0] !== 12'b0011_1100_1111) begin
      errors++;
      $display("FAIL frame_head got=%b expected=%b", led_hist[11:0], 12'b0011_1100_1111);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (irq !== 1'b1 || led !== 1'b0) begin
        errors++;
        $display("FAIL hold cyc=%0d got irq=%b led=%b expected irq=1 led=0", i, irq, led);
      end
    end
    ack("hold");
    step();
    checks++;
    if (irq !== 1'b0 || led !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_ack got irq=%b led=%b expected 0 0", irq, led);
    end
  endtask

  task automatic test_data_change();
    start_frame(16'h4FB6);
    check_frame(16'h4FB6, "data_chg", 1'b1, 1'b0);
    ack("data_chg");
  endtask

  task automatic test_start_drop();
    start_frame(16'h1234);
    check_frame(16'h1234, "start_drop", 1'b0, 1'b1);
    step();
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL start_drop clear got irq=%b expected 0", irq);
    end
  endtask

  task automatic test_reset_midframe();
    logic e;
    start_frame(16'h4FB6);
    for (int k = 0; k < 19; k++) begin
      e = exp_led(k, 16'h4FB6);
      checks++;
      if (led !== e) begin
        errors++;
        $display("FAIL pre_reset k=%0d got=%b expected=%b", k, led, e);
      end
      step();
    end
    // Now #1 after E0+19; reset is sampled at E0+20
    reset = 1'b1;
    start = 1'b0;
    step();
    checks++;
    if (led !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got led=%b irq=%b expected 0 0", led, irq);
    end
    reset = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step();
      checks++;
      if (led !== 1'b0 || irq !== 1'b0) begin
        errors++;
        $display("FAIL post_reset cyc=%0d got led=%b irq=%b expected 0 0", i, led, irq);
      end
    end
    start_frame(16'hA5C3);
    check_frame(16'hA5C3, "after_reset", 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    // irq is high from the previous frame with start still 1
    ack("b2b");
    start_frame(16'hFFFF);
    check_frame(16'hFFFF, "b2b", 1'b0, 1'b0);
    checks++;
    if (led_hist[11:4] !== 8'b0011_0011) begin
      errors++;
      $display("FAIL b2b_head got=%b expected=%b", led_hist[11:4], 8'b0011_0011);
    end
    ack("b2b_end");
  endtask

  initial begin
    test_reset();
    test_frame_hold();
    test_data_change();
    test_start_drop();
    test_reset_midframe();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
